// File: rtl/game2048_ctrl.sv
// Turn sequencer for the 2048 game: key accept, move/merge handshake, random tile spawn, win/lose check.
// Optional macro GAME2048_KEEP_PLAYING_EN lets the player continue from the win state.
module game2048_ctrl #(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned SCORE_W     = 20,
  parameter int unsigned FOUR_THRESH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         direction,
  input  logic               merge_moved,
  input  logic [SCORE_W-1:0] merge_score,
  input  logic [15:0]        empty_mask,
  input  logic               win_flag,
  input  logic               can_move,
  output logic [3:0]         move_dir,
  output logic               board_clear,
  output logic               board_load,
  output logic               spawn_en,
  output logic [3:0]         spawn_idx,
  output logic               spawn_four,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         game_state,
  output logic               busy
);

  localparam logic [2:0] S_START = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_MOVE  = 3'd2;
  localparam logic [2:0] S_SPAWN = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_WIN   = 3'd5;
  localparam logic [2:0] S_LOSE  = 3'd6;

  localparam logic [1:0] GS_NONE = 2'b00;
  localparam logic [1:0] GS_PLAY = 2'b01;
  localparam logic [1:0] GS_WIN  = 2'b10;
  localparam logic [1:0] GS_LOSE = 2'b11;

  // An all-zero seed would lock the LFSR up.
  localparam logic [15:0] SEED   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [4:0]  FOUR_T = 5'(FOUR_THRESH);

  logic [2:0]         state, state_nxt;
  logic [15:0]        lfsr;
  logic               key_armed, armed_nxt;
  logic [3:0]         ptr, ptr_nxt;
  logic [1:0]         spawn_cnt, cnt_nxt;
  logic [SCORE_W-1:0] score_nxt;
  logic [1:0]         gs_nxt;
  logic [3:0]         dir_nxt;
  logic               busy_nxt;
  logic               clear_c, load_c, spawn_c;
  logic               key_onehot, accept;
  logic               win_hit;
  logic [SCORE_W:0]   score_sum;
`ifdef GAME2048_KEEP_PLAYING_EN
  logic               win_seen, win_seen_nxt;
`endif

  assign key_onehot = (direction != 4'd0) && ((direction & (direction - 4'd1)) == 4'd0);
  assign accept     = key_onehot && key_armed;
  assign score_sum  = {1'b0, score} + {1'b0, merge_score};

`ifdef GAME2048_KEEP_PLAYING_EN
  assign win_hit = win_flag && !win_seen;
`else
  assign win_hit = win_flag;
`endif

  // Pulses are decoded from the registered state and masked during reset.
  assign board_clear = clear_c & ~rst;
  assign board_load  = load_c  & ~rst;
  assign spawn_en    = spawn_c & ~rst;
  assign spawn_idx   = ptr;
  assign spawn_four  = ({1'b0, lfsr[7:4]} < FOUR_T);

  // Next-state and datapath control
  always_comb begin
    state_nxt = state;
    armed_nxt = key_armed | (direction == 4'd0);
    ptr_nxt   = ptr;
    cnt_nxt   = spawn_cnt;
    score_nxt = score;
    gs_nxt    = game_state;
    dir_nxt   = move_dir;
    clear_c   = 1'b0;
    load_c    = 1'b0;
    spawn_c   = 1'b0;
`ifdef GAME2048_KEEP_PLAYING_EN
    win_seen_nxt = win_seen;
`endif

    case (state)
      S_START: begin
        clear_c   = 1'b1;
        cnt_nxt   = 2'd2;
        ptr_nxt   = lfsr[3:0];
        state_nxt = S_SPAWN;
      end
      S_IDLE: begin
        if (accept) begin
          dir_nxt   = direction;
          armed_nxt = 1'b0;
          state_nxt = S_MOVE;
        end
      end
      S_MOVE: begin
        if (merge_moved) begin
          load_c    = 1'b1;
          score_nxt = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
          cnt_nxt   = 2'd1;
          ptr_nxt   = lfsr[3:0];
          state_nxt = S_SPAWN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_SPAWN: begin
        if (empty_mask == 16'h0000) begin
          state_nxt = S_CHECK;
        end else if (empty_mask[ptr]) begin
          spawn_c = 1'b1;
          cnt_nxt = spawn_cnt - 2'd1;
          if (spawn_cnt == 2'd1) begin
            state_nxt = S_CHECK;
          end else begin
            ptr_nxt = lfsr[3:0];
          end
        end else begin
          ptr_nxt = ptr + 4'd1;
        end
      end
      S_CHECK: begin
        if (win_hit) begin
          state_nxt = S_WIN;
`ifdef GAME2048_KEEP_PLAYING_EN
          win_seen_nxt = 1'b1;
`endif
        end else if (!can_move) begin
          state_nxt = S_LOSE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WIN: begin
`ifdef GAME2048_KEEP_PLAYING_EN
        if (accept) begin
          dir_nxt   = direction;
          armed_nxt = 1'b0;
          gs_nxt    = GS_PLAY;
          state_nxt = S_MOVE;
        end
`else
        state_nxt = S_WIN;
`endif
      end
      S_LOSE: begin
        state_nxt = S_LOSE;
      end
      default: begin
        state_nxt = S_START;
      end
    endcase

    // game_state tracks the resting states only, so it stays 00 through the opening sequence.
    if (state_nxt == S_IDLE) begin
      gs_nxt = GS_PLAY;
    end else if (state_nxt == S_WIN) begin
      gs_nxt = GS_WIN;
    end else if (state_nxt == S_LOSE) begin
      gs_nxt = GS_LOSE;
    end

    busy_nxt = (state_nxt == S_START) || (state_nxt == S_MOVE) ||
               (state_nxt == S_SPAWN) || (state_nxt == S_CHECK);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_START;
      lfsr       <= SEED;
      key_armed  <= 1'b0;
      ptr        <= 4'd0;
      spawn_cnt  <= 2'd0;
      score      <= '0;
      game_state <= GS_NONE;
      move_dir   <= 4'd0;
      busy       <= 1'b1;
`ifdef GAME2048_KEEP_PLAYING_EN
      win_seen   <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      key_armed  <= armed_nxt;
      ptr        <= ptr_nxt;
      spawn_cnt  <= cnt_nxt;
      score      <= score_nxt;
      game_state <= gs_nxt;
      move_dir   <= dir_nxt;
      busy       <= busy_nxt;
`ifdef GAME2048_KEEP_PLAYING_EN
      win_seen   <= win_seen_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_game2048_ctrl.sv
// Directed bench for game2048_ctrl with a small empty-cell model of the board datapath.
module tb_game2048_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  direction;
  logic        merge_moved;
  logic [19:0] merge_score;
  logic [15:0] empty_mask;
  logic        win_flag;
  logic        can_move;
  logic [3:0]  move_dir;
  logic        board_clear;
  logic        board_load;
  logic        spawn_en;
  logic [3:0]  spawn_idx;
  logic        spawn_four;
  logic [19:0] score;
  logic [1:0]  game_state;
  logic        busy;

  logic        auto_mask;
  logic [15:0] forced_mask;
  logic [15:0] mask_q;
  logic [15:0] m_lfsr;

  int n_chk;
  int n_err;

  int n_clear, n_load, n_spawn, n_busy;
  int b_clear, b_load, b_spawn, b_busy;
  int lat_cnt, last_lat;
  logic [3:0] ptr0, sp_prev, sp_last;
  logic       sp_four, sp_four_exp, sp_hit;

  game2048_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .direction   (direction),
    .merge_moved (merge_moved),
    .merge_score (merge_score),
    .empty_mask  (empty_mask),
    .win_flag    (win_flag),
    .can_move    (can_move),
    .move_dir    (move_dir),
    .board_clear (board_clear),
    .board_load  (board_load),
    .spawn_en    (spawn_en),
    .spawn_idx   (spawn_idx),
    .spawn_four  (spawn_four),
    .score       (score),
    .game_state  (game_state),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign empty_mask = auto_mask ? mask_q : forced_mask;

  // Reference LFSR (taps 16,14,13,11) and board empty-cell model
  always @(posedge clk) begin
    if (rst) begin
      m_lfsr <= 16'hACE1;
      mask_q <= 16'hFFFF;
    end else begin
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      if (board_clear) mask_q <= 16'hFFFF;
      else if (spawn_en) mask_q[spawn_idx] <= 1'b0;
    end
  end

  // Event recorder, sampled mid-cycle
  always @(negedge clk) begin
    n_clear <= n_clear + int'(board_clear);
    n_load  <= n_load + int'(board_load);
    n_spawn <= n_spawn + int'(spawn_en);
    n_busy  <= n_busy + int'(busy);
    if (board_load) begin
      ptr0    <= m_lfsr[3:0];
      lat_cnt <= 0;
    end else begin
      lat_cnt <= lat_cnt + 1;
    end
    if (spawn_en) begin
      last_lat    <= lat_cnt + 1;
      sp_prev     <= sp_last;
      sp_last     <= spawn_idx;
      sp_four     <= spawn_four;
      sp_four_exp <= (m_lfsr[7:4] < 4'd2);
      sp_hit      <= empty_mask[spawn_idx];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark();
    b_clear = n_clear;
    b_load  = n_load;
    b_spawn = n_spawn;
    b_busy  = n_busy;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic turn(input logic [3:0] d, input int hold);
    direction = d;
    tick(hold);
    direction = 4'd0;
  endtask

  int exp_lat;

  initial begin
    n_chk = 0; n_err = 0;
    n_clear = 0; n_load = 0; n_spawn = 0; n_busy = 0;
    lat_cnt = 0; last_lat = 0;
    ptr0 = 4'd0; sp_prev = 4'd0; sp_last = 4'd0;
    sp_four = 1'b0; sp_four_exp = 1'b0; sp_hit = 1'b0;
    rst = 1'b1; direction = 4'd0; merge_moved = 1'b0; merge_score = 20'd0;
    win_flag = 1'b0; can_move = 1'b1; auto_mask = 1'b1; forced_mask = 16'hFFFF;

    // Reset values and opening sequence
    tick(3);
    check("rst_gs", 32'(game_state), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_dir", 32'(move_dir), 32'd0);
    check("rst_clear", 32'(board_clear), 32'd0);
    check("rst_spawn", 32'(spawn_en), 32'd0);
    mark();
    rst = 1'b0;
    @(negedge clk);
    check("clear_c1", 32'(board_clear), 32'd1);
    check("gs_start", 32'(game_state), 32'd0);
    tick(1);
    wait_idle("idle_start", 60);
    check("start_spawns", 32'(n_spawn - b_spawn), 32'd2);
    check("start_clears", 32'(n_clear - b_clear), 32'd1);
    check("start_distinct", 32'(sp_prev != sp_last), 32'd1);
    check("start_gs", 32'(game_state), 32'd1);
    check("start_score", 32'(score), 32'd0);
    check("four", 32'(sp_four), 32'(sp_four_exp));

    // Held left key yields exactly one turn
    mark();
    merge_moved = 1'b1; merge_score = 20'd8;
    turn(4'b0100, 10);
    wait_idle("idle_left", 40);
    check("left_load", 32'(n_load - b_load), 32'd1);
    check("left_dir", 32'(move_dir), 32'b0100);
    check("left_score", 32'(score), 32'd8);
    check("left_spawn", 32'(n_spawn - b_spawn), 32'd1);
    check("left_hit", 32'(sp_hit), 32'd1);
    check("four", 32'(sp_four), 32'(sp_four_exp));

    // Multi-hot key is ignored
    mark();
    turn(4'b0110, 5);
    tick(1);
    check("mhot_busy", 32'(n_busy - b_busy), 32'd0);
    check("mhot_load", 32'(n_load - b_load), 32'd0);
    check("mhot_gs", 32'(game_state), 32'd1);

    // No-move turn returns straight to IDLE
    mark();
    merge_moved = 1'b0;
    direction = 4'b1000;
    tick(6);
    check("nomove_busy", 32'(n_busy - b_busy), 32'd1);
    check("nomove_spawn", 32'(n_spawn - b_spawn), 32'd0);
    check("nomove_score", 32'(score), 32'd8);
    check("nomove_dir", 32'(move_dir), 32'b1000);

    // Switching keys without a release is not a new turn
    mark();
    merge_moved = 1'b1;
    turn(4'b0001, 6);
    tick(1);
    check("norel_busy", 32'(n_busy - b_busy), 32'd0);
    check("norel_load", 32'(n_load - b_load), 32'd0);
    check("norel_dir", 32'(move_dir), 32'b1000);

    // First-probe hit: MOVE, SPAWN, CHECK
    mark();
    auto_mask = 1'b0; forced_mask = 16'hFFFF; merge_score = 20'd4;
    turn(4'b0010, 8);
    tick(2);
    check("lat_busy", 32'(n_busy - b_busy), 32'd3);
    check("lat_score", 32'(score), 32'd12);
    check("lat_spawn", 32'(n_spawn - b_spawn), 32'd1);
    check("four", 32'(sp_four), 32'(sp_four_exp));

    // Single empty cell: probe walks to cell 15
    mark();
    forced_mask = 16'h8000; merge_score = 20'hFFFE4;
    turn(4'b1000, 2);
    wait_idle("idle_walk", 40);
    exp_lat = int'(4'(4'd15 - ptr0)) + 1;
    check("walk_idx", 32'(sp_last), 32'd15);
    check("walk_lat", 32'(last_lat), 32'(exp_lat));
    check("walk_score", 32'(score), 32'hFFFF0);
    check("walk_spawn", 32'(n_spawn - b_spawn), 32'd1);

    // Score saturates
    merge_score = 20'h20;
    turn(4'b0100, 2);
    wait_idle("idle_sat", 40);
    check("sat_score", 32'(score), 32'hFFFFF);

    // Win
    forced_mask = 16'hFFFF; merge_score = 20'd0; win_flag = 1'b1;
    turn(4'b0001, 2);
    wait_idle("idle_win", 40);
    check("win_gs", 32'(game_state), 32'd2);
    win_flag = 1'b0;
    mark();
    tick(1);
    turn(4'b0100, 6);
    tick(1);
`ifdef GAME2048_KEEP_PLAYING_EN
    check("win_cont_gs", 32'(game_state), 32'd1);
    check("win_cont_load", 32'(n_load - b_load), 32'd1);
`else
    check("win_hold_gs", 32'(game_state), 32'd2);
    check("win_hold_busy", 32'(n_busy - b_busy), 32'd0);
    check("win_hold_load", 32'(n_load - b_load), 32'd0);
`endif

    // Reset, then lose on the first check
    rst = 1'b1;
    tick(2);
    check("rst2_gs", 32'(game_state), 32'd0);
    check("rst2_score", 32'(score), 32'd0);
    auto_mask = 1'b1; can_move = 1'b0;
    rst = 1'b0;
    tick(1);
    wait_idle("idle_lose", 60);
    check("lose_gs", 32'(game_state), 32'd3);

    // Reset in the middle of SPAWN aborts the opening
    can_move = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    mark();
    tick(1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_spawn", 32'(spawn_en), 32'd0);
    tick(1);
    rst = 1'b0;
    check("abort_cnt", 32'(n_spawn - b_spawn), 32'd0);
    @(negedge clk);
    check("abort_clear", 32'(board_clear), 32'd1);
    check("abort_gs", 32'(game_state), 32'd0);
    tick(1);
    wait_idle("idle_abort", 60);
    check("abort_spawns", 32'(n_spawn - b_spawn), 32'd2);
    check("abort_clears", 32'(n_clear - b_clear), 32'd2);
    check("abort_play", 32'(game_state), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
